// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package addsub_pkg;

  // Control states of the serial engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Default operand/result width.
  localparam int unsigned ADDSUB_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Ports: a, b - addend bits; c - carry in; s - sum bit; cr - carry out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic cr
);

  assign s  = a ^ b ^ c;
  assign cr = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/subtract engine: accepts two operands over a valid/ready
// handshake, ripples them LSB first through a single full_adder cell (one bit
// per clock) and presents result, carry and signed overflow over a second
// valid/ready handshake.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand handshake (a, b, sub)
//   out_valid/out_ready   - result handshake (result, carry_out, overflow)
//   bit_out/bit_valid     - serial tap of the sum bit produced each cycle
module bit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             bit_out,
  output logic             bit_valid
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             carry_out_q, carry_out_d;
  logic             ovf_q, ovf_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;

  logic fa_s;
  logic fa_cr;

  // Single adder cell fed by the low bits of the operand shift registers.
  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .cr (fa_cr)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      carry_out_q <= 1'b0;
      ovf_q       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      carry_out_q <= carry_out_d;
      ovf_q       <= ovf_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    carry_out_d = carry_out_q;
    ovf_d       = ovf_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here, seed carry with sub.
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = sub;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        // Sum enters at the MSB so bit i lands at position i after WIDTH shifts.
        res_d       = {fa_s, res_q[WIDTH-1:1]};
        carry_d     = fa_cr;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_out_d   = fa_s;
        bit_valid_d = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          carry_out_d = fa_cr;
          // Signed overflow: carry into the MSB differs from carry out of it.
          ovf_d       = fa_cr ^ carry_q;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign carry_out = carry_out_q;
  assign overflow  = ovf_q;
  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Self-checking bench for bit_serial_addsub: directed and random operations
// compared against an arithmetic reference model.
module tb_bit_serial_addsub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         bit_out;
  logic         bit_valid;

  int n_checks = 0;
  int n_pass   = 0;

  bit_serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: returns {overflow, carry, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
    int ux, uy, sx, sy, r, sr;
    logic c, v;
    int lim;
    ux  = int'(x);
    uy  = int'(y);
    sx  = int'($signed(x));
    sy  = int'($signed(y));
    lim = 1 << (W - 1);
    if (s) begin
      r  = ux - uy;
      c  = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = ux + uy;
      c  = (r >= (1 << W));
      sr = sx + sy;
    end
    v = (sr >= lim) || (sr < -lim);
    model = {v, c, W'(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with optional backpressure and ignored junk requests.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                       input int bp, input bit junk);
    logic [W+1:0] exp;
    int n;
    exp = model(xa, xb, xs);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("wait_in_ready_timeout", 32'(in_ready), 32'd1);
    a = xa; b = xb; sub = xs; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    for (int i = 0; i < int'(W); i++) begin
      tick();
      check("bit_valid", 32'(bit_valid), 32'd1);
      check("bit_out", 32'(bit_out), 32'(exp[i]));
      if (i == int'(W) - 2) check("out_valid_early", 32'(out_valid), 32'd0);
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom_range(0, 1));
      end
    end
    check("out_valid_latency", 32'(out_valid), 32'd1);
    for (int k = 0; k < bp; k++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_result", 32'({overflow, carry_out, result}), 32'(exp));
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        a = W'($urandom);
      end
    end
    in_valid = 1'b0;
    check("result", 32'(result), 32'(exp[W-1:0]));
    check("carry_out", 32'(carry_out), 32'(exp[W]));
    check("overflow", 32'(overflow), 32'(exp[W+1]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_cleared", 32'(out_valid), 32'd0);
    check("in_ready_restored", 32'(in_ready), 32'd1);
    check("result_held", 32'(result), 32'(exp[W-1:0]));
  endtask

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         s;
  } op_t;

  initial begin
    op_t          q[$];
    op_t          cur;
    logic [W+1:0] e;
    int           last_acc;
    int           cyc;
    int           done_cnt;
    bit           acc_now;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({carry_out, overflow, bit_out, bit_valid}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    do_op(8'h05, 8'h03, 1'b1, 5, 1'b1);
    do_op(8'h05, 8'hFD, 1'b0, 0, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1, 1'b0);
    do_op(8'h00, 8'h01, 1'b1, 2, 1'b1);
    do_op(8'h80, 8'h01, 1'b1, 0, 1'b0);

    // Random operations.
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Back-to-back with in_valid and out_ready held high.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
    in_valid = 1'b1; out_ready = 1'b1;
    last_acc = -1; done_cnt = 0; cyc = 0;
    while (done_cnt < 4 && cyc < 200) begin
      acc_now = in_ready && in_valid;
      if (acc_now) begin
        q.push_back('{x: a, y: b, s: sub});
        if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
        last_acc = cyc;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("b2b_unexpected_result", 32'd1, 32'd0);
        else begin
          cur = q.pop_front();
          e = model(cur.x, cur.y, cur.s);
          check("b2b_result", 32'({overflow, carry_out, result}), 32'(e));
        end
        done_cnt++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom_range(0, 1));
      end
    end
    if (done_cnt < 4) check("b2b_timeout", 32'(done_cnt), 32'd4);
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("b2b_drained_out_valid", 32'(out_valid), 32'd0);

    // Reset while the counter sits at 4.
    while (!in_ready) tick();
    a = 8'h7F; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_bit_valid", 32'(bit_valid), 32'd0);
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      check("midrst_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(8'h05, 8'h03, 1'b1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bit_serial_addsub.md
Name: bit_serial_addsub

Overview:
Sequential bit-serial add/subtract engine. It accepts two WIDTH-bit operands over a valid/ready handshake and processes one bit per clock, LSB first, through a single full_adder cell with a registered carry. It returns the WIDTH-bit result with carry and signed-overflow flags over a second valid/ready handshake. It is the hardware responder for the existing bit-serial full_adder stimulus flow and is the datapath building block for the 8-bit subtractor.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  A+B or A-B, modulo 2^WIDTH
carry_out  output  1  final carry (subtract: 1 = no borrow)
overflow  output  1  two's-complement overflow
bit_out  output  1  sum bit produced this cycle (debug/serial tap)
bit_valid  output  1  bit_out is valid this cycle

Behaviour:
- Clock is clk; reset is synchronous, active-low, on rst_n. It is sampled only on the rising clk edge.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, bit_out=0, bit_valid=0, counter=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On an edge with in_valid=1, latch a into shift register A.
  - Latch sub ? ~b : b into shift register B.
  - Set the carry register to sub, clear the counter, go to RUN.
- RUN: in_ready=0; in_valid is ignored.
  - Each edge feeds A[0], B[0] and the carry register into full_adder.
  - Shift the sum bit into result from the MSB side, so after WIDTH shifts bit i sits at position i.
  - Store the cell carry in the carry register, shift A and B right, and increment the counter.
  - bit_valid=1 and bit_out=sum for the cycle following each processed bit.
  - On the edge processing bit WIDTH-1:
    - carry_out = cell carry.
    - overflow = cell carry XOR carry into that bit.
    - Go to DONE with out_valid=1.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles minimum.
- DONE: out_valid=1.
  - result, carry_out and overflow are held stable while out_ready=0, for any duration.
  - On an edge with out_ready=1, clear out_valid and go to IDLE. Outputs keep their last values until the next operation overwrites them.
  - in_ready=0 in DONE, so no new accept can occur on the same edge as result consumption.
- Arithmetic:
  - Subtraction is A + ~B + 1.
  - carry_out is the raw final carry (not inverted), so a borrow shows as carry_out=0.
  - All arithmetic is modulo 2^WIDTH.
- Reset mid-operation: rst_n=0 on any edge in RUN or DONE aborts the operation and restores all reset values. No partial result is ever flagged valid.
- Input values are sampled only on the accepting edge. Changes to a, b or sub afterwards have no effect.

Decomposition:
- Package addsub_pkg holds:
  - the state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant 8.
- Sub-module: full_adder, the existing team cell (ports a, b, c, s, cr), instantiated once. The top level holds the FSM, counter, shift registers and the carry register.

Test Plan:
- Subtract: a=8'h05, b=8'h03, sub=1 -> after 8 cycles result=8'h02, carry_out=1, overflow=0; bit_out sequence LSB-first 0,1,0,0,0,0,0,0.
- Add with negative operand: a=8'h05, b=8'hFD, sub=0 -> result=8'h02, carry_out=1, overflow=0. This also covers the full 8-bit ripple, including bit 7.
- Overflow and borrow:
  - 8'h7F+8'h01 -> result=8'h80, carry_out=0, overflow=1.
  - 8'h00-8'h01 -> result=8'hFF, carry_out=0, overflow=0.
  - 8'h80-8'h01 -> result=8'h7F, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result, carry_out and overflow stay constant and in_ready=0. Pulse in_valid with new operands during RUN and during DONE -> ignored; result unchanged.
- Back-to-back: keep in_valid=1 and out_ready=1 continuously -> accepts spaced exactly WIDTH+2 cycles apart, each result correct.
- Reset mid-run: assert rst_n=0 for one edge at counter=4 -> next cycle out_valid=0, in_ready=1, result=0. A following operation 8'h05-8'h03 gives 8'h02.
